// File: rtl/memory_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: controller modes, sequencer
// states and funct3 constants.
// Optional feature macro: JZJCOREF_MEMSEQ_DEBUG_PORT_EN (no effect on this file).
package JZJCoreFTypes;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  // The SEQ_ prefix keeps these names apart from the MemoryMode_t literals.
  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_LOAD_ADDR = 3'd1,
    SEQ_LOAD_DATA = 3'd2,
    SEQ_PRELOAD   = 3'd3,
    SEQ_STORE     = 3'd4,
    SEQ_FAULT     = 3'd5
  } MemSeqState_t;

  localparam logic [2:0] FUNCT3_SW = 3'b010;

endpackage

// File: rtl/memory_access_sequencer_if.sv
// Request/response and memory-controller bundle of the memory access sequencer.
// The master side is the sequencer; the slave side is the core, the debug
// requester and the memory controller.
// Optional feature macro: JZJCOREF_MEMSEQ_DEBUG_PORT_EN adds the debug requester.
interface memory_access_sequencer_if;
  import JZJCoreFTypes::*;

  logic        coreReq;
  logic        coreIsStore;
  logic [2:0]  coreFunct3;
  logic        coreAck;
  logic        loadValid;
  MemoryMode_t memoryMode;
  logic [2:0]  funct3Out;
  logic        sourceSelect;
  logic        memoryUnalignedAccess;
  logic        memoryBadFunct3;
  logic        fault;
  logic [1:0]  faultCause;
`ifdef JZJCOREF_MEMSEQ_DEBUG_PORT_EN
  logic        dbgReq;
  logic        dbgIsStore;
  logic [2:0]  dbgFunct3;
  logic        dbgAck;

  modport master (
    input  coreReq, coreIsStore, coreFunct3, memoryUnalignedAccess, memoryBadFunct3,
    input  dbgReq, dbgIsStore, dbgFunct3,
    output coreAck, loadValid, memoryMode, funct3Out, sourceSelect, fault, faultCause,
    output dbgAck
  );

  modport slave (
    output coreReq, coreIsStore, coreFunct3, memoryUnalignedAccess, memoryBadFunct3,
    output dbgReq, dbgIsStore, dbgFunct3,
    input  coreAck, loadValid, memoryMode, funct3Out, sourceSelect, fault, faultCause,
    input  dbgAck
  );
`else
  modport master (
    input  coreReq, coreIsStore, coreFunct3, memoryUnalignedAccess, memoryBadFunct3,
    output coreAck, loadValid, memoryMode, funct3Out, sourceSelect, fault, faultCause
  );

  modport slave (
    output coreReq, coreIsStore, coreFunct3, memoryUnalignedAccess, memoryBadFunct3,
    input  coreAck, loadValid, memoryMode, funct3Out, sourceSelect, fault, faultCause
  );
`endif

endinterface

// File: rtl/memory_access_sequencer_arbiter.sv
// Round-robin arbiter between the core and the debug requester for the single
// memory-controller data port. Only exists when JZJCOREF_MEMSEQ_DEBUG_PORT_EN
// is defined.
`ifdef JZJCOREF_MEMSEQ_DEBUG_PORT_EN
module memory_request_arbiter (
  input  logic clock,
  input  logic reset,
  input  logic coreReq,
  input  logic dbgReq,
  input  logic grantEnable,
  output logic grantValid,
  output logic grantDbg
);

  // 1 = debug was granted last; resetting to debug lets the core win the first tie.
  logic lastGrant;

  assign grantValid = coreReq | dbgReq;
  assign grantDbg   = dbgReq & (~coreReq | ~lastGrant);

  // Remember the winner of every grant actually taken by the sequencer.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant <= 1'b1;
    end else if (grantEnable && grantValid) begin
      lastGrant <= grantDbg;
    end
  end

endmodule
`endif

// File: rtl/memory_access_sequencer.sv
// Sequences memoryMode/funct3 for the memory controller so that every load
// and store (stores always via a preload cycle) completes, and traps
// controller errors into a sticky fault.
// Optional feature macro: JZJCOREF_MEMSEQ_DEBUG_PORT_EN adds a debug requester
// and round-robin arbitration; without it the core is always granted.
//
// state         | meaning
// SEQ_IDLE      | memoryMode NOP, waiting for a grant
// SEQ_LOAD_ADDR | memoryMode LOAD, error flags checked
// SEQ_LOAD_DATA | memoryMode LOAD, loadValid and ack
// SEQ_PRELOAD   | memoryMode STORE_PRELOAD, error flags checked
// SEQ_STORE     | memoryMode STORE, write at end of cycle, ack
// SEQ_FAULT     | sticky fault, requests ignored until reset
module memory_access_sequencer (
  input logic clock,
  input logic reset,
  memory_access_sequencer_if.master bus
);
  import JZJCoreFTypes::*;

  MemSeqState_t state;
  MemoryMode_t  modeReg;
  logic [2:0]   funct3Reg;
  logic         srcReg;
  logic         ackReg;
  logic         loadValidReg;
  logic         faultReg;
  logic [1:0]   causeReg;

  logic         grantValid;
  logic         grantDbg;
  logic         reqIsStore;
  logic [2:0]   reqFunct3;
  logic         memError;

`ifdef JZJCOREF_MEMSEQ_DEBUG_PORT_EN
  memory_request_arbiter arbiter (
    .clock       (clock),
    .reset       (reset),
    .coreReq     (bus.coreReq),
    .dbgReq      (bus.dbgReq),
    .grantEnable (state == SEQ_IDLE),
    .grantValid  (grantValid),
    .grantDbg    (grantDbg)
  );

  assign reqIsStore = grantDbg ? bus.dbgIsStore : bus.coreIsStore;
  assign reqFunct3  = grantDbg ? bus.dbgFunct3  : bus.coreFunct3;
  assign bus.dbgAck = ackReg & srcReg & ~reset;
`else
  assign grantValid = bus.coreReq;
  assign grantDbg   = 1'b0;
  assign reqIsStore = bus.coreIsStore;
  assign reqFunct3  = bus.coreFunct3;
`endif

  assign memError = bus.memoryUnalignedAccess | bus.memoryBadFunct3;

  // Reset gates mode and strobes immediately so a reset during STORE blocks the write.
  assign bus.memoryMode   = reset ? NOP : modeReg;
  assign bus.coreAck      = ackReg & ~srcReg & ~reset;
  assign bus.loadValid    = loadValidReg & ~reset;
  assign bus.funct3Out    = funct3Reg;
  assign bus.sourceSelect = srcReg;
  assign bus.fault        = faultReg;
  assign bus.faultCause   = causeReg;

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SEQ_IDLE;
      modeReg      <= NOP;
      funct3Reg    <= 3'b000;
      srcReg       <= 1'b0;
      ackReg       <= 1'b0;
      loadValidReg <= 1'b0;
      faultReg     <= 1'b0;
      causeReg     <= 2'b00;
    end else begin
      ackReg       <= 1'b0;
      loadValidReg <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          modeReg <= NOP;
          if (grantValid) begin
            funct3Reg <= reqFunct3;
            srcReg    <= grantDbg;
            state     <= reqIsStore ? SEQ_PRELOAD : SEQ_LOAD_ADDR;
            modeReg   <= reqIsStore ? STORE_PRELOAD : LOAD;
          end
        end
        SEQ_LOAD_ADDR: begin
          if (memError) begin
            state    <= SEQ_FAULT;
            modeReg  <= NOP;
            faultReg <= 1'b1;
            causeReg <= {bus.memoryUnalignedAccess, bus.memoryBadFunct3};
          end else begin
            state        <= SEQ_LOAD_DATA;
            modeReg      <= LOAD;
            loadValidReg <= 1'b1;
            ackReg       <= 1'b1;
          end
        end
        SEQ_PRELOAD: begin
          if (memError) begin
            state    <= SEQ_FAULT;
            modeReg  <= NOP;
            faultReg <= 1'b1;
            causeReg <= {bus.memoryUnalignedAccess, bus.memoryBadFunct3};
          end else begin
            state   <= SEQ_STORE;
            modeReg <= STORE;
            ackReg  <= 1'b1;
          end
        end
        SEQ_LOAD_DATA, SEQ_STORE: begin
          state   <= SEQ_IDLE;
          modeReg <= NOP;
        end
        SEQ_FAULT: begin
          modeReg <= NOP;
        end
        default: begin
          state   <= SEQ_IDLE;
          modeReg <= NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed bench for memory_access_sequencer: loads, stores, faults, reset
// during STORE and (when JZJCOREF_MEMSEQ_DEBUG_PORT_EN is defined) arbitration.
module tb_memory_access_sequencer;
  import JZJCoreFTypes::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  memory_access_sequencer_if bus ();

  memory_access_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Move to the sample point of the current cycle.
  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idleInputs();
    bus.coreReq = 1'b0;
    bus.coreIsStore = 1'b0;
    bus.coreFunct3 = 3'b000;
    bus.memoryUnalignedAccess = 1'b0;
    bus.memoryBadFunct3 = 1'b0;
`ifdef JZJCOREF_MEMSEQ_DEBUG_PORT_EN
    bus.dbgReq = 1'b0;
    bus.dbgIsStore = 1'b0;
    bus.dbgFunct3 = 3'b000;
`endif
  endtask

  task automatic applyReset();
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    idleInputs();
    applyReset();

    // Reset values (first cycle after release, still IDLE).
    sample();
    checkValue("rst mode", bus.memoryMode, NOP);
    checkValue("rst coreAck", bus.coreAck, 0);
    checkValue("rst loadValid", bus.loadValid, 0);
    checkValue("rst fault", bus.fault, 0);
    checkValue("rst faultCause", bus.faultCause, 2'b00);
    checkValue("rst funct3Out", bus.funct3Out, 3'b000);
    checkValue("rst sourceSelect", bus.sourceSelect, 0);

    // Core lw: request sampled at N.
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b0; bus.coreFunct3 = FUNCT3_SW;
    sample();
    checkValue("lw N mode", bus.memoryMode, NOP);
    nextCycle(); sample();
    checkValue("lw N+1 mode", bus.memoryMode, LOAD);
    checkValue("lw N+1 loadValid", bus.loadValid, 0);
    checkValue("lw N+1 ack", bus.coreAck, 0);
    nextCycle(); sample();
    checkValue("lw N+2 mode", bus.memoryMode, LOAD);
    checkValue("lw N+2 loadValid", bus.loadValid, 1);
    checkValue("lw N+2 ack", bus.coreAck, 1);
    checkValue("lw N+2 funct3Out", bus.funct3Out, 3'b010);
    nextCycle();
    bus.coreReq = 1'b0;
    sample();
    checkValue("lw N+3 mode", bus.memoryMode, NOP);
    checkValue("lw N+3 loadValid", bus.loadValid, 0);
    checkValue("lw N+3 ack", bus.coreAck, 0);

    // Core sb, funct3 000.
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b1; bus.coreFunct3 = 3'b000;
    sample();
    checkValue("sb N mode", bus.memoryMode, NOP);
    nextCycle(); sample();
    checkValue("sb N+1 mode", bus.memoryMode, STORE_PRELOAD);
    checkValue("sb N+1 ack", bus.coreAck, 0);
    checkValue("sb N+1 funct3Out", bus.funct3Out, 3'b000);
    nextCycle(); sample();
    checkValue("sb N+2 mode", bus.memoryMode, STORE);
    checkValue("sb N+2 ack", bus.coreAck, 1);
    checkValue("sb N+2 funct3Out", bus.funct3Out, 3'b000);
    nextCycle();
    bus.coreReq = 1'b0;
    sample();
    checkValue("sb N+3 mode", bus.memoryMode, NOP);
    checkValue("sb N+3 ack", bus.coreAck, 0);

    // sw with reset asserted during the STORE cycle.
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b1; bus.coreFunct3 = FUNCT3_SW;
    nextCycle(); sample();
    checkValue("rstSt preload mode", bus.memoryMode, STORE_PRELOAD);
    nextCycle();
    reset = 1'b1;
    sample();
    checkValue("rstSt mode", bus.memoryMode, NOP);
    checkValue("rstSt ack", bus.coreAck, 0);
    nextCycle();
    reset = 1'b0;
    bus.coreReq = 1'b0;
    sample();
    checkValue("rstSt after mode", bus.memoryMode, NOP);
    checkValue("rstSt after ack", bus.coreAck, 0);
    checkValue("rstSt funct3Out", bus.funct3Out, 3'b000);
    nextCycle(); sample();
    checkValue("rstSt idle mode", bus.memoryMode, NOP);

    // sh with badFunct3 during PRELOAD.
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b1; bus.coreFunct3 = 3'b001;
    nextCycle();
    bus.memoryBadFunct3 = 1'b1;
    sample();
    checkValue("sh preload mode", bus.memoryMode, STORE_PRELOAD);
    nextCycle();
    bus.memoryBadFunct3 = 1'b0;
    sample();
    checkValue("sh fault", bus.fault, 1);
    checkValue("sh faultCause", bus.faultCause, 2'b01);
    checkValue("sh fault mode", bus.memoryMode, NOP);
    checkValue("sh fault ack", bus.coreAck, 0);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); sample();
      checkValue("sh held mode", bus.memoryMode, NOP);
      checkValue("sh held ack", bus.coreAck, 0);
      checkValue("sh held fault", bus.fault, 1);
    end
    bus.coreReq = 1'b0;
    applyReset();
    sample();
    checkValue("sh cleared fault", bus.fault, 0);
    checkValue("sh cleared cause", bus.faultCause, 2'b00);

    // lw with unaligned flag during LOAD_ADDR.
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b0; bus.coreFunct3 = FUNCT3_SW;
    nextCycle();
    bus.memoryUnalignedAccess = 1'b1;
    sample();
    checkValue("lwU addr mode", bus.memoryMode, LOAD);
    nextCycle();
    bus.memoryUnalignedAccess = 1'b0;
    sample();
    checkValue("lwU fault", bus.fault, 1);
    checkValue("lwU faultCause", bus.faultCause, 2'b10);
    checkValue("lwU mode", bus.memoryMode, NOP);
    checkValue("lwU loadValid", bus.loadValid, 0);
    checkValue("lwU ack", bus.coreAck, 0);
    bus.coreReq = 1'b0;
    nextCycle();
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle(); sample();
      checkValue("lwU ignored mode", bus.memoryMode, NOP);
      checkValue("lwU ignored ack", bus.coreAck, 0);
      checkValue("lwU ignored cause", bus.faultCause, 2'b10);
    end
    bus.coreReq = 1'b0;

`ifdef JZJCOREF_MEMSEQ_DEBUG_PORT_EN
    // Both requesters high from reset release: core first, then debug.
    reset = 1'b1;
    bus.coreReq = 1'b1; bus.coreIsStore = 1'b0; bus.coreFunct3 = FUNCT3_SW;
    bus.dbgReq = 1'b1; bus.dbgIsStore = 1'b1; bus.dbgFunct3 = 3'b000;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    sample();
    checkValue("arb N mode", bus.memoryMode, NOP);
    nextCycle(); sample();
    checkValue("arb core sel", bus.sourceSelect, 0);
    checkValue("arb core mode", bus.memoryMode, LOAD);
    nextCycle(); sample();
    checkValue("arb coreAck", bus.coreAck, 1);
    checkValue("arb no dbgAck", bus.dbgAck, 0);
    nextCycle();
    bus.coreReq = 1'b0;
    sample();
    checkValue("arb gap mode", bus.memoryMode, NOP);
    nextCycle(); sample();
    checkValue("arb dbg sel", bus.sourceSelect, 1);
    checkValue("arb dbg mode", bus.memoryMode, STORE_PRELOAD);
    nextCycle(); sample();
    checkValue("arb dbg store", bus.memoryMode, STORE);
    checkValue("arb dbgAck", bus.dbgAck, 1);
    checkValue("arb dbg no coreAck", bus.coreAck, 0);
    checkValue("arb dbg funct3Out", bus.funct3Out, 3'b000);
    nextCycle();
    bus.dbgReq = 1'b0;
    sample();
    checkValue("arb end mode", bus.memoryMode, NOP);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
